spike_event_scheduler: RTL and testbench

- Round-robin arbiter plus event FIFO that shares the event-driven spike processor among NUM_SRC spike sources.
- Sources present events (address plus timestamp). The scheduler grants one source per cycle and buffers the granted event.
- It issues buffered events to the processor one at a time, using a single-cycle event_valid pulse, and waits for event_processed or a timeout before issuing the next.
- Sits between the neuron-core spike outputs and the processor's event queue interface.

---
 rtl/spike_event_scheduler_if.sv | 27 ++
 rtl/spike_event_scheduler.sv | 174 +++++++++++++++++
 tb/tb_spike_event_scheduler.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/spike_event_scheduler_if.sv
// Spike source / processor bus bundle for the spike event scheduler.
// Latency: n/a (wiring only).
// Backpressure: sources hold src_req until granted; the processor ends each event with event_processed.
//   master modport: the spike sources plus the processor (drive requests, data and completions)
//   slave  modport: the scheduler (drives grants and issued events)
interface spike_event_scheduler_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]   src_req;
    logic [8*NUM_SRC-1:0] src_addr;
    logic [8*NUM_SRC-1:0] src_time;
    logic [NUM_SRC-1:0]   src_grant;
    logic [7:0]           event_addr;
    logic [7:0]           event_time;
    logic                 event_valid;
    logic                 event_processed;

    modport slave (
        input  src_req, src_addr, src_time, event_processed,
        output src_grant, event_addr, event_time, event_valid
    );

    modport master (
        output src_req, src_addr, src_time, event_processed,
        input  src_grant, event_addr, event_time, event_valid
    );
endinterface

// File: rtl/spike_event_scheduler.sv
// Round-robin arbiter plus event FIFO that shares one spike processor among NUM_SRC sources.
// Latency: request to grant 1 cycle; the granted event is written on the grant edge and popped on the next edge.
// Backpressure: no grants while the FIFO is full; one event is outstanding until event_processed or timeout.
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : gates new grants and new issues (an in-flight handshake still completes)
//   bus             : source requests/grants and processor event/valid/processed handshake
//   fifo_count/full/empty, busy, stall_cycles, timeout_events : status and statistics
module spike_event_scheduler #(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    spike_event_scheduler_if.slave      bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic                        busy,
    output logic [15:0]                 stall_cycles,
    output logic [15:0]                 timeout_events
);
    localparam int IDXW = $clog2(NUM_SRC);
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int WCW  = $clog2(TIMEOUT) + 1;
    localparam logic [WCW-1:0]  TMO_LAST = WCW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0] ev_time;
        logic [7:0] ev_addr;
    } event_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1
    } state_t;

    // Registers
    state_t            state_q;
    logic [IDXW-1:0]   rr_ptr_q;
    logic [NUM_SRC-1:0] grant_q;
    logic [PTRW-1:0]   wr_ptr_q;
    logic [PTRW-1:0]   rd_ptr_q;
    logic [CNTW-1:0]   count_q;
    logic [WCW-1:0]    wait_cnt_q;
    event_t            ev_q;
    logic              ev_vld_q;
    logic [15:0]       stall_q;
    logic [15:0]       tmo_q;
    event_t            mem_q [FIFO_DEPTH];

    // Arbitration
    logic [NUM_SRC-1:0] req_eff;
    logic               win_found;
    logic [IDXW-1:0]    win_idx;
    logic [IDXW-1:0]    rr_ptr_d;
    int unsigned        cand;
    event_t             win_ev;
    logic               push;
    logic               pop;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign fifo_count = count_q;
    assign busy       = (state_q == S_WAIT);

    // A source whose grant is visible this cycle may still show req; mask it
    // so the same request is not captured twice.
    assign req_eff = bus.src_req & ~grant_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_SRC;
            if (!win_found && req_eff[cand]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(cand);
            end
        end
        rr_ptr_d = IDXW'((int'(win_idx) + 1) % NUM_SRC);
    end

    assign win_ev.ev_addr = bus.src_addr[8*win_idx +: 8];
    assign win_ev.ev_time = bus.src_time[8*win_idx +: 8];

    assign push = enable && !fifo_full && win_found;
    assign pop  = (state_q == S_IDLE) && enable && !fifo_empty;

    // Event storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= win_ev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
            ev_q       <= '0;
            ev_vld_q   <= 1'b0;
            stall_q    <= '0;
            tmo_q      <= '0;
        end else begin
            // Ingress
            grant_q <= '0;
            if (push) begin
                grant_q[win_idx] <= 1'b1;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
                rr_ptr_q         <= rr_ptr_d;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if ((|bus.src_req) && fifo_full && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end

            // Egress
            case (state_q)
                S_IDLE: begin
                    ev_vld_q <= 1'b0;
                    if (pop) begin
                        ev_q       <= mem_q[rd_ptr_q];
                        ev_vld_q   <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    ev_vld_q <= 1'b0;
                    // Completion wins over a coincident timeout.
                    if (bus.event_processed) begin
                        state_q <= S_IDLE;
                    end else if (wait_cnt_q == TMO_LAST) begin
                        if (tmo_q != 16'hFFFF) begin
                            tmo_q <= tmo_q + 16'd1;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    ev_vld_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.src_grant   = grant_q;
    assign bus.event_addr  = ev_q.ev_addr;
    assign bus.event_time  = ev_q.ev_time;
    assign bus.event_valid = ev_vld_q;
    assign stall_cycles    = stall_q;
    assign timeout_events  = tmo_q;
endmodule

// File: tb/tb_spike_event_scheduler.sv
// Directed bench for spike_event_scheduler: reset, single event, round robin,
// FIFO full/stall with timeout, simultaneous push/pop, enable gating, async reset.
module tb_spike_event_scheduler;
    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        busy;
    logic [15:0] stall_cycles;
    logic [15:0] timeout_events;

    int passed = 0;
    int total  = 0;

    spike_event_scheduler_if #(.NUM_SRC(4)) ifc ();

    spike_event_scheduler #(
        .NUM_SRC   (4),
        .FIFO_DEPTH(8),
        .TIMEOUT   (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .bus           (ifc),
        .fifo_count    (fifo_count),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .busy          (busy),
        .stall_cycles  (stall_cycles),
        .timeout_events(timeout_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n               = 1'b0;
        enable              = 1'b0;
        ifc.src_req         = '0;
        ifc.event_processed = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int cd;
        int ngr;
        int seen;
        int gq[$];
        int aq[$];

        rst_n               = 1'b0;
        enable              = 1'b0;
        ifc.src_req         = '0;
        ifc.src_addr        = '0;
        ifc.src_time        = '0;
        ifc.event_processed = 1'b0;
        #3;
        chk("rst_grant", 32'(ifc.src_grant), 0);
        chk("rst_valid", 32'(ifc.event_valid), 0);
        chk("rst_addr", 32'(ifc.event_addr), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stall", 32'(stall_cycles), 0);
        chk("rst_tmo", 32'(timeout_events), 0);
        #9;
        rst_n = 1'b1;

        // Single event from source 2
        tick();
        enable               = 1'b1;
        ifc.src_addr[23:16]  = 8'h2B;
        ifc.src_time[23:16]  = 8'h10;
        ifc.src_req          = 4'b0100;
        tick();
        chk("a_grant", 32'(ifc.src_grant), 32'b0100);
        chk("a_count", 32'(fifo_count), 1);
        ifc.src_req = '0;
        tick();
        chk("a_grant_off", 32'(ifc.src_grant), 0);
        chk("a_valid", 32'(ifc.event_valid), 1);
        chk("a_addr", 32'(ifc.event_addr), 32'h2B);
        chk("a_time", 32'(ifc.event_time), 32'h10);
        chk("a_busy", 32'(busy), 1);
        tick();
        chk("a_valid_pulse", 32'(ifc.event_valid), 0);
        chk("a_busy_hold", 32'(busy), 1);
        ifc.event_processed = 1'b1;
        tick();
        ifc.event_processed = 1'b0;
        chk("a_busy_done", 32'(busy), 0);
        chk("a_empty", 32'(fifo_empty), 1);
        chk("a_addr_hold", 32'(ifc.event_addr), 32'h2B);

        // Round robin, all sources requesting, ack 3 cycles after valid
        do_reset();
        for (int i = 0; i < 4; i++) ifc.src_addr[8*i +: 8] = 8'hA0 + 8'(i);
        enable      = 1'b1;
        ifc.src_req = 4'b1111;
        cd          = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            for (int i = 0; i < 4; i++) if (ifc.src_grant[i]) gq.push_back(i);
            ifc.event_processed = 1'b0;
            if (ifc.event_valid) begin
                aq.push_back(int'(ifc.event_addr));
                cd = 3;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) ifc.event_processed = 1'b1;
            end
        end
        chk("b_ngrants", 32'(gq.size() >= 8), 1);
        chk("b_naddrs", 32'(aq.size() >= 8), 1);
        for (int i = 0; i < 8 && i < gq.size(); i++) chk($sformatf("b_grant%0d", i), 32'(gq[i]), 32'(i % 4));
        for (int i = 0; i < 8 && i < aq.size(); i++) chk($sformatf("b_addr%0d", i), 32'(aq[i]), 32'hA0 + 32'(i % 4));

        // FIFO full, stall counting, timeout
        do_reset();
        enable               = 1'b1;
        ifc.src_addr[15:8]   = 8'h55;
        ifc.src_addr[7:0]    = 8'h77;
        ifc.src_req          = 4'b0010;
        tick();
        chk("c_grant1", 32'(ifc.src_grant), 32'b0010);
        ifc.src_req = '0;
        tick();
        chk("c_valid1", 32'(ifc.event_valid), 1);
        chk("c_addr1", 32'(ifc.event_addr), 32'h55);
        ifc.src_req = 4'b0001;
        ngr = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (ifc.src_grant[0]) ngr++;
        end
        chk("c_ngrants", 32'(ngr), 8);
        chk("c_full", 32'(fifo_full), 1);
        chk("c_count8", 32'(fifo_count), 8);
        chk("c_no_grant", 32'(ifc.src_grant), 0);
        chk("c_stall5", 32'(stall_cycles), 5);
        for (int j = 21; j <= 63; j++) tick();
        chk("c_busy63", 32'(busy), 1);
        chk("c_tmo63", 32'(timeout_events), 0);
        tick();
        chk("c_tmo64", 32'(timeout_events), 1);
        chk("c_busy64", 32'(busy), 0);
        chk("c_count64", 32'(fifo_count), 8);
        tick();
        chk("c_valid65", 32'(ifc.event_valid), 1);
        chk("c_addr65", 32'(ifc.event_addr), 32'h77);
        chk("c_count7", 32'(fifo_count), 7);
        chk("c_stall50", 32'(stall_cycles), 50);
        ifc.src_req = '0;

        // Simultaneous push and pop, then enable gating
        do_reset();
        ifc.src_addr = 32'h44332211;
        enable       = 1'b1;
        ifc.src_req  = 4'b0011;
        tick();
        chk("d_grant0", 32'(ifc.src_grant), 32'b0001);
        chk("d_count1", 32'(fifo_count), 1);
        ifc.src_req = 4'b0010;
        tick();
        chk("d_grant1", 32'(ifc.src_grant), 32'b0010);
        chk("d_valid", 32'(ifc.event_valid), 1);
        chk("d_addr", 32'(ifc.event_addr), 32'h11);
        chk("d_count_same", 32'(fifo_count), 1);
        enable      = 1'b0;
        ifc.src_req = 4'b0100;
        tick();
        chk("d_dis_grant", 32'(ifc.src_grant), 0);
        chk("d_dis_busy", 32'(busy), 1);
        ifc.event_processed = 1'b1;
        tick();
        ifc.event_processed = 1'b0;
        chk("d_ack_idle", 32'(busy), 0);
        seen = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (ifc.event_valid || (ifc.src_grant != 0)) seen++;
        end
        chk("d_dis_quiet", 32'(seen), 0);
        chk("d_dis_count", 32'(fifo_count), 1);
        enable = 1'b1;
        tick();
        chk("d_en_valid", 32'(ifc.event_valid), 1);
        chk("d_en_addr", 32'(ifc.event_addr), 32'h22);
        chk("d_en_grant", 32'(ifc.src_grant), 32'b0100);
        chk("d_en_count", 32'(fifo_count), 1);

        // Async reset with 5 queued events and a handshake in flight
        ifc.src_req = 4'b1011;
        for (int j = 0; j < 4; j++) tick();
        ifc.src_req = '0;
        chk("e_count5", 32'(fifo_count), 5);
        chk("e_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("e_rst_count", 32'(fifo_count), 0);
        chk("e_rst_empty", 32'(fifo_empty), 1);
        chk("e_rst_busy", 32'(busy), 0);
        chk("e_rst_addr", 32'(ifc.event_addr), 0);
        chk("e_rst_tmo", 32'(timeout_events), 0);
        chk("e_rst_grant", 32'(ifc.src_grant), 0);
        #3;
        rst_n = 1'b1;
        seen = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (ifc.event_valid) seen++;
        end
        chk("e_no_stale", 32'(seen), 0);
        chk("e_post_empty", 32'(fifo_empty), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
